// File: rtl/collisions_reader.sv
// Collision-RAM scanner: reads count 64-bit entries from base_addr (wrapping at 1024)
// and emits each as four 16-bit words, low word first. Optional: COLLISIONS_READER_SKIP_ZERO_EN.
module collisions_reader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] count,
    output logic [9:0]  rd_adb,
    output logic        rd_ceb,
    output logic        rd_oce,
    input  logic [63:0] rd_dout,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [10:0] remaining_q, remaining_d;
    logic [63:0] hold_q, hold_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = count;
                    state_d     = (count != 11'd0) ? S_READ : S_DONE;
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                hold_d      = rd_dout;
                idx_d       = 2'd0;
                remaining_d = remaining_q - 11'd1;
                addr_d      = addr_q + 10'd1;
                state_d     = S_SEND;
`ifdef COLLISIONS_READER_SKIP_ZERO_EN
                // all-zero entry produces no words; remaining_q still holds the pre-decrement value
                if (rd_dout == '0)
                    state_d = (remaining_q != 11'd1) ? S_READ : S_DONE;
`endif
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == 2'd3)
                        state_d = (remaining_q != 11'd0) ? S_READ : S_DONE;
                    else
                        idx_d = idx_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
        end
    end

    assign rd_oce    = 1'b1;
    assign rd_ceb    = (state_q == S_READ);
    assign rd_adb    = (state_q == S_READ) ? addr_q : '0;
    assign out_valid = (state_q == S_SEND);
    assign out_data  = (state_q == S_SEND) ? hold_q[{idx_q, 4'b0000} +: 16] : '0;
    assign out_last  = (state_q == S_SEND) && (idx_q == 2'd3) && (remaining_q == 11'd0);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
